robot_sensor_conditioner: RTL and testbench

Upstream stage of the synchronous robot control FSM.
- Takes the two raw, asynchronous proximity sensor lines.
- Synchronises each line, then debounces it.
- Delivers clean, glitch-free S1/S2 levels to the control FSM, plus a change strobe and a glitch statistic for diagnostics.

---
 rtl/robot_sensor_pkg.sv | 16 +
 rtl/robot_sensor_conditioner_chan.sv | 124 ++++++++++++
 rtl/robot_sensor_conditioner.sv | 78 +++++++
 tb/tb_robot_sensor_conditioner.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/robot_sensor_pkg.sv
// Shared types and default constants for the proximity sensor conditioner.
package robot_sensor_pkg;

  // Per-channel debounce state; encoding is fixed at 00/01/10/11.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b10,
    PEND_LO   = 2'b11
  } chan_state_t;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned GLITCH_W_DEF        = 8;

endpackage

// File: rtl/robot_sensor_conditioner_chan.sv
// One sensor channel: synchroniser chain, debounce FSM and run-length counter.
module sensor_debounce_chan
  import robot_sensor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic raw,
  output logic level,
  output logic commit_c,
  output logic glitch_c
);

  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic        ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  chan_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   level_q, level_d;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign level   = level_q;

  // Synchroniser chain; runs regardless of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // State, counter and output level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Debounce next-state logic; a run ending early is reported as a glitch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    commit_c = 1'b0;
    glitch_c = 1'b0;
    if (!enable) begin
      state_d = level_q ? STABLE_HI : STABLE_LO;
      cnt_d   = '0;
    end else begin
      case (state_q)
        STABLE_LO: if (synced) begin
          if (ONE_SHOT) begin
            state_d  = STABLE_HI;
            level_d  = 1'b1;
            commit_c = 1'b1;
          end else begin
            state_d = PEND_HI;
            cnt_d   = CNT_W'(1);
          end
        end
        PEND_HI: if (synced) begin
          if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
            state_d  = STABLE_HI;
            cnt_d    = '0;
            level_d  = 1'b1;
            commit_c = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d  = STABLE_LO;
          cnt_d    = '0;
          glitch_c = 1'b1;
        end
        STABLE_HI: if (!synced) begin
          if (ONE_SHOT) begin
            state_d  = STABLE_LO;
            level_d  = 1'b0;
            commit_c = 1'b1;
          end else begin
            state_d = PEND_LO;
            cnt_d   = CNT_W'(1);
          end
        end
        PEND_LO: if (!synced) begin
          if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
            state_d  = STABLE_LO;
            cnt_d    = '0;
            level_d  = 1'b0;
            commit_c = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d  = STABLE_HI;
          cnt_d    = '0;
          glitch_c = 1'b1;
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/robot_sensor_conditioner.sv
// Conditions two raw proximity sensors into clean S1/S2 levels with diagnostics.
module robot_sensor_conditioner
  import robot_sensor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned GLITCH_W        = GLITCH_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                s1_raw,
  input  logic                s2_raw,
  input  logic                glitch_clr,
  output logic                S1,
  output logic                S2,
  output logic                change,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int unsigned SUM_W = GLITCH_W + 1;

  logic                commit1_c, commit2_c, glitch1_c, glitch2_c;
  logic [1:0]          glitch_inc;
  logic [SUM_W-1:0]    glitch_sum;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                change_q;

  sensor_debounce_chan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan1 (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .raw     (s1_raw),
    .level   (S1),
    .commit_c(commit1_c),
    .glitch_c(glitch1_c)
  );

  sensor_debounce_chan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan2 (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .raw     (s2_raw),
    .level   (S2),
    .commit_c(commit2_c),
    .glitch_c(glitch2_c)
  );

  assign glitch_inc   = 2'(glitch1_c) + 2'(glitch2_c);
  assign glitch_sum   = {1'b0, glitch_q} + SUM_W'(glitch_inc);
  assign change       = change_q;
  assign glitch_count = glitch_q;

  // Saturating glitch accumulation; clear wins over a same-cycle increment.
  always_comb begin
    glitch_d = glitch_sum[GLITCH_W-1:0];
    if (glitch_sum[GLITCH_W]) glitch_d = '1;
    if (glitch_clr)           glitch_d = '0;
  end

  // Change strobe lands on the same edge the levels update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      change_q <= 1'b0;
      glitch_q <= '0;
    end else begin
      change_q <= commit1_c | commit2_c;
      glitch_q <= glitch_d;
    end
  end

endmodule

// File: tb/tb_robot_sensor_conditioner.sv
// Self-checking bench for robot_sensor_conditioner against a run-length reference model.
module tb_robot_sensor_conditioner;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned GW   = 8;
  localparam int          GMAX = (1 << GW) - 1;

  logic          clk = 1'b0;
  logic          reset, enable, s1_raw, s2_raw, glitch_clr;
  logic          S1, S2, change;
  logic [GW-1:0] glitch_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: input delay line, output level, length of the
  // current run of samples disagreeing with the output, diagnostics.
  logic m_sync [2][SYNC];
  logic m_out  [2];
  int   m_run  [2];
  logic m_change;
  int   m_gc;

  robot_sensor_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .GLITCH_W       (GW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .s1_raw      (s1_raw),
    .s2_raw      (s2_raw),
    .glitch_clr  (glitch_clr),
    .S1          (S1),
    .S2          (S2),
    .change      (change),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < int'(SYNC); i++) m_sync[c][i] = 1'b0;
      m_out[c] = 1'b0;
      m_run[c] = 0;
    end
    m_change = 1'b0;
    m_gc     = 0;
  endfunction

  // One clock edge: an output flips after DEB consecutive disagreeing
  // synchronised samples; a shorter disagreeing run is a glitch.
  function automatic void model_edge();
    int   glitches;
    logic any;
    logic synced;
    glitches = 0;
    any      = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 2; c++) begin
      synced = m_sync[c][SYNC-1];
      for (int i = int'(SYNC) - 1; i > 0; i--) m_sync[c][i] = m_sync[c][i-1];
      m_sync[c][0] = (c == 0) ? s1_raw : s2_raw;
      if (!enable) begin
        m_run[c] = 0;
      end else if (synced != m_out[c]) begin
        m_run[c]++;
        if (m_run[c] == int'(DEB)) begin
          m_out[c] = ~m_out[c];
          m_run[c] = 0;
          any      = 1'b1;
        end
      end else begin
        if (m_run[c] > 0) glitches++;
        m_run[c] = 0;
      end
    end
    m_change = any;
    if (glitch_clr) m_gc = 0;
    else            m_gc = (m_gc + glitches > GMAX) ? GMAX : m_gc + glitches;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("S1", 32'(S1), 32'(m_out[0]));
    check("S2", 32'(S2), 32'(m_out[1]));
    check("change", 32'(change), 32'(m_change));
    check("glitch_count", 32'(glitch_count), 32'(m_gc));
  endtask

  // Drive inputs, take one clock edge, advance the model, compare.
  task automatic step(input logic r1, input logic r2, input logic en, input logic clr);
    s1_raw     = r1;
    s2_raw     = r2;
    enable     = en;
    glitch_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    int changes;
    reset = 1'b1; enable = 1'b1; s1_raw = 1'b0; s2_raw = 1'b0; glitch_clr = 1'b0;
    model_reset();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("reset_S1", 32'(S1), 32'd0);
    check("reset_S2", 32'(S2), 32'd0);
    check("reset_change", 32'(change), 32'd0);
    check("reset_glitch", 32'(glitch_count), 32'd0);
    #2 reset = 1'b0;

    // S2 rises at edge SYNC+DEB with a single change pulse.
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 1, 0);
      if (i == 5) check("t1_S2_before", 32'(S2), 32'd0);
      if (i == 6) begin
        check("t1_S2_rise", 32'(S2), 32'd1);
        check("t1_change", 32'(change), 32'd1);
      end
      if (i == 7) check("t1_change_gone", 32'(change), 32'd0);
    end

    // Three-cycle pulse on s1 is rejected and counted once.
    repeat (3) step(1, 1, 1, 0);
    repeat (6) step(0, 1, 1, 0);
    check("t2_S1", 32'(S1), 32'd0);
    check("t2_glitch", 32'(glitch_count), 32'd1);

    // Both rise together: one change pulse, both outputs in the same cycle.
    repeat (10) step(0, 0, 1, 0);
    changes = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1, 1, 1, 0);
      if (change) changes++;
      if (i == 6) check("t3_both", 32'({S1, S2}), 32'd3);
    end
    check("t3_single_pulse", 32'(changes), 32'd1);
    repeat (10) step(0, 0, 1, 0);

    // Repeated short pulses saturate the counter; clear wins over a glitch.
    repeat (300) begin
      step(0, 1, 1, 0);
      step(0, 1, 1, 0);
      repeat (4) step(0, 0, 1, 0);
    end
    check("t4_saturated", 32'(glitch_count), 32'(GMAX));
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    check("t4_clear", 32'(glitch_count), 32'd0);
    step(0, 0, 1, 0);

    // Disabled: outputs frozen; re-enable needs a full debounce run.
    repeat (10) step(1, 0, 0, 0);
    check("t5_frozen", 32'(S1), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 1, 0);
      check("t5_enable_rise", 32'(S1), (i == 4) ? 32'd1 : 32'd0);
    end
    repeat (8) step(0, 0, 1, 0);

    // Async reset mid-debounce, then full latency again after release.
    repeat (5) step(1, 0, 1, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("t6_async_S1", 32'(S1), 32'd0);
    check("t6_async_change", 32'(change), 32'd0);
    repeat (2) step(1, 0, 1, 0);
    #2 reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 1, 0);
      check("t6_latency", 32'(S1), (i >= 6) ? 32'd1 : 32'd0);
    end

    // Random segments of held inputs, enable drops and clears.
    repeat (600) begin
      logic r1, r2, en, clr;
      int   len;
      r1  = 1'($urandom_range(0, 1));
      r2  = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 31) == 0);
      len = $urandom_range(1, 7);
      repeat (len) step(r1, r2, en, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
